// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Scoreboard-based read-after-write hazard detector and stall controller for
// the in-order RV32 core. Every issued instruction occupies one slot of a
// WB_LATENCY-deep shift register. A register is pending while any slot holds a
// valid write to it, so a decoded source that is still in flight holds the
// front end and sends bubbles downstream until the write reaches the
// register file.

module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int WB_LATENCY = 3,
    parameter int CNT_W      = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [REG_ADDR_W-1:0]      id_rs1,
    input  logic [REG_ADDR_W-1:0]      id_rs2,
    input  logic                       id_uses_rs1,
    input  logic                       id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]      id_rd,
    input  logic                       id_reg_write,
    input  logic                       flush,
    output logic                       pc_write,
    output logic                       if_id_write,
    output logic                       bubble,
    output logic                       raw_hazard,
    output logic [2**REG_ADDR_W-1:0]   busy_mask,
    output logic [CNT_W-1:0]           stall_count,
    output logic [CNT_W-1:0]           issue_count,
    output logic                       hazard_error
);

    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int CONSEC_W = $clog2(WB_LATENCY + 2);
    localparam logic [CONSEC_W-1:0] CONSEC_LIMIT = CONSEC_W'(WB_LATENCY + 1);
    localparam logic [CONSEC_W-1:0] CONSEC_TRIP  = CONSEC_W'(WB_LATENCY);

    // Slot 0 is the youngest in-flight instruction; the oldest slot is
    // written to the register file on the edge it shifts out.
    logic [WB_LATENCY-1:0]                  r_slotValid;
    logic [WB_LATENCY-1:0][REG_ADDR_W-1:0]  r_slotRd;
    logic [NUM_REGS-1:0]                    r_busyMask;
    logic [CNT_W-1:0]                       r_stallCount;
    logic [CNT_W-1:0]                       r_issueCount;
    logic [CONSEC_W-1:0]                    r_consecStall;
    logic                                   r_hazardError;

    logic [WB_LATENCY-1:0]                  w_slotValidNext;
    logic [WB_LATENCY-1:0][REG_ADDR_W-1:0]  w_slotRdNext;
    logic [NUM_REGS-1:0]                    w_pendingMask;
    logic [NUM_REGS-1:0]                    w_busyMaskNext;
    logic                                   w_rs1Pending;
    logic                                   w_rs2Pending;
    logic                                   w_hazard;
    logic                                   w_stall;
    logic                                   w_issue;

    // Decode the current slots into a one-hot-per-register pending set; x0 is never pending
    always_comb begin
        w_pendingMask = '0;
        for (int i = 0; i < WB_LATENCY; i++) begin
            if (r_slotValid[i]) begin
                w_pendingMask[r_slotRd[i]] = 1'b1;
            end
        end
        w_pendingMask[0] = 1'b0;
    end

    assign w_rs1Pending = id_uses_rs1 && w_pendingMask[id_rs1];
    assign w_rs2Pending = id_uses_rs2 && w_pendingMask[id_rs2];
    assign w_hazard     = !reset && id_valid && (w_rs1Pending || w_rs2Pending);
    assign w_stall      = w_hazard && !flush;
    assign w_issue      = !reset && id_valid && !w_hazard && !flush;

    // Build the next scoreboard contents: new entry only on a real issue of a non-x0 writer
    always_comb begin
        w_slotValidNext    = '0;
        w_slotRdNext       = '0;
        w_slotValidNext[0] = w_issue && id_reg_write && (id_rd != '0);
        w_slotRdNext[0]    = w_issue ? id_rd : '0;
        for (int i = 1; i < WB_LATENCY; i++) begin
            w_slotValidNext[i] = r_slotValid[i-1];
            w_slotRdNext[i]    = r_slotRd[i-1];
        end
    end

    // Registered busy mask mirrors the scoreboard contents that will be present after this edge
    always_comb begin
        w_busyMaskNext = '0;
        for (int i = 0; i < WB_LATENCY; i++) begin
            if (w_slotValidNext[i]) begin
                w_busyMaskNext[w_slotRdNext[i]] = 1'b1;
            end
        end
    end

    // Front-end control: reset holds everything, flush beats stall, stall freezes PC and IF/ID
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        bubble      = !id_valid;
        raw_hazard  = w_hazard;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
        end else if (flush) begin
            bubble      = 1'b1;
        end else if (w_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
        end
    end

    // Scoreboard shift, busy mask, saturating counters and the sticky over-long-stall flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_slotValid   <= '0;
            r_slotRd      <= '0;
            r_busyMask    <= '0;
            r_stallCount  <= '0;
            r_issueCount  <= '0;
            r_consecStall <= '0;
            r_hazardError <= 1'b0;
        end else begin
            r_slotValid <= w_slotValidNext;
            r_slotRd    <= w_slotRdNext;
            r_busyMask  <= w_busyMaskNext;
            if (w_stall && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
            if (w_issue && (r_issueCount != '1)) begin
                r_issueCount <= r_issueCount + CNT_W'(1);
            end
            if (w_stall) begin
                if (r_consecStall != CONSEC_LIMIT) begin
                    r_consecStall <= r_consecStall + CONSEC_W'(1);
                end
                if (r_consecStall >= CONSEC_TRIP) begin
                    r_hazardError <= 1'b1;
                end
            end else begin
                r_consecStall <= '0;
            end
        end
    end

    assign busy_mask    = r_busyMask;
    assign stall_count  = r_stallCount;
    assign issue_count  = r_issueCount;
    assign hazard_error = r_hazardError;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Drives directed instruction sequences and a randomized phase into
// hazard_stall_ctrl. A reference model keeps a list of in-flight writes with
// their remaining lifetime and predicts every output each cycle; a small
// register-file model executes the issued instructions so that a wrong stall
// decision shows up as a wrong architectural value.

module tb_hazard_stall_ctrl;

    localparam int RW   = 5;
    localparam int WB   = 3;
    localparam int CW   = 6;
    localparam int NREG = 32;

    localparam int OP_ADDI = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [RW-1:0]   id_rs1;
    logic [RW-1:0]   id_rs2;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [RW-1:0]   id_rd;
    logic            id_reg_write;
    logic            flush;
    logic            pc_write;
    logic            if_id_write;
    logic            bubble;
    logic            raw_hazard;
    logic [NREG-1:0] busy_mask;
    logic [CW-1:0]   stall_count;
    logic [CW-1:0]   issue_count;
    logic            hazard_error;

    hazard_stall_ctrl #(
        .REG_ADDR_W (RW),
        .WB_LATENCY (WB),
        .CNT_W      (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .flush        (flush),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .bubble       (bubble),
        .raw_hazard   (raw_hazard),
        .busy_mask    (busy_mask),
        .stall_count  (stall_count),
        .issue_count  (issue_count),
        .hazard_error (hazard_error)
    );

    // Free-running core clock
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Reference model state: outstanding writes with edges left until the register file sees them
    typedef struct packed {
        int rd;
        int remaining;
    } wbEntry_t;

    wbEntry_t inFlight[$];
    int       mStallCnt;
    int       mIssueCnt;
    int       mConsec;
    bit       mHazErr;
    bit       modelEnable   = 1'b0;
    bit       compareEnable = 1'b0;
    bit       mHz;
    bit       mIs;
    int       cntMax;

    function automatic bit mPending(input int r);
        if (r == 0) return 1'b0;
        foreach (inFlight[i]) begin
            if (inFlight[i].rd == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit mHazard();
        return !reset && id_valid &&
               ((id_uses_rs1 && mPending(int'(id_rs1))) || (id_uses_rs2 && mPending(int'(id_rs2))));
    endfunction

    function automatic logic [NREG-1:0] mBusyMask();
        logic [NREG-1:0] m;
        m = '0;
        foreach (inFlight[i]) m[inFlight[i].rd] = 1'b1;
        return m;
    endfunction

    // Advance the reference model on each active edge
    always @(posedge clock) begin
        cntMax = (1 << CW) - 1;
        if (modelEnable) begin
            if (reset) begin
                inFlight.delete();
                mStallCnt = 0;
                mIssueCnt = 0;
                mConsec   = 0;
                mHazErr   = 1'b0;
            end else begin
                mHz = mHazard();
                mIs = id_valid && !mHz && !flush;
                for (int i = inFlight.size() - 1; i >= 0; i--) begin
                    inFlight[i].remaining = inFlight[i].remaining - 1;
                    if (inFlight[i].remaining == 0) inFlight.delete(i);
                end
                if (mIs && id_reg_write && (id_rd != '0)) inFlight.push_back('{rd: int'(id_rd), remaining: WB});
                if (mHz && !flush) begin
                    if (mStallCnt < cntMax) mStallCnt++;
                    mConsec++;
                    if (mConsec >= WB + 1) mHazErr = 1'b1;
                end else begin
                    mConsec = 0;
                end
                if (mIs && mIssueCnt < cntMax) mIssueCnt++;
            end
        end
    end

    // Compare every DUT output against the model in the middle of each cycle
    logic expPc, expIfId, expBubble, expHaz;
    always @(negedge clock) begin
        if (compareEnable) begin
            expHaz    = mHazard();
            expPc     = 1'b1;
            expIfId   = 1'b1;
            expBubble = !id_valid;
            if (reset) begin
                expPc = 1'b0; expIfId = 1'b0; expBubble = 1'b1;
            end else if (flush) begin
                expBubble = 1'b1;
            end else if (expHaz) begin
                expPc = 1'b0; expIfId = 1'b0; expBubble = 1'b1;
            end
            checkOutput("raw_hazard",   64'(raw_hazard),   64'(expHaz));
            checkOutput("pc_write",     64'(pc_write),     64'(expPc));
            checkOutput("if_id_write",  64'(if_id_write),  64'(expIfId));
            checkOutput("bubble",       64'(bubble),       64'(expBubble));
            checkOutput("busy_mask",    64'(busy_mask),    64'(mBusyMask()));
            checkOutput("stall_count",  64'(stall_count),  64'(mStallCnt));
            checkOutput("issue_count",  64'(issue_count),  64'(mIssueCnt));
            checkOutput("hazard_error", 64'(hazard_error), 64'(mHazErr));
        end
    end

    // Register-file execution model driven by what the DUT actually lets through
    typedef struct packed {
        int rd;
        int value;
        int remaining;
    } execEntry_t;

    int         regs[NREG];
    execEntry_t execQ[$];
    int         curOp;
    int         curImm;
    bit         dutIssueSample;
    int         execVal;

    always @(negedge clock) begin
        dutIssueSample = !reset && id_valid && pc_write && !flush;
    end

    always @(posedge clock) begin
        if (reset) begin
            foreach (regs[i]) regs[i] = 0;
            execQ.delete();
        end else begin
            execVal = 0;
            if (dutIssueSample) begin
                case (curOp)
                    OP_ADD:  execVal = regs[id_rs1] + regs[id_rs2];
                    OP_SUB:  execVal = regs[id_rs1] - regs[id_rs2];
                    default: execVal = regs[id_rs1] + curImm;
                endcase
            end
            for (int i = execQ.size() - 1; i >= 0; i--) begin
                execQ[i].remaining = execQ[i].remaining - 1;
            end
            while (execQ.size() > 0 && execQ[0].remaining == 0) begin
                if (execQ[0].rd != 0) regs[execQ[0].rd] = execQ[0].value;
                void'(execQ.pop_front());
            end
            if (dutIssueSample && id_reg_write && id_rd != '0) begin
                execQ.push_back('{rd: int'(id_rd), value: execVal, remaining: WB});
            end
        end
    end

    task automatic applyStimulus(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                                 input int rd, input bit rw, input bit fl);
        id_valid     = v;
        id_rs1       = rs1[RW-1:0];
        id_rs2       = rs2[RW-1:0];
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        id_rd        = rd[RW-1:0];
        id_reg_write = rw;
        flush        = fl;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        reset = 1'b0;
    endtask

    // Hold one instruction in decode until the DUT lets it issue; reports the stall cycles seen
    task automatic runInstr(input int op, input int rd, input int rs1, input int rs2, input int imm,
                            output int stalls);
        bit done;
        curOp  = op;
        curImm = imm;
        applyStimulus(1, rs1, rs2, 1, op != OP_ADDI, rd, 1, 0);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clock);
            if (pc_write) done = 1'b1;
            else stalls++;
            nextCycle();
        end
        checkOutput("issueWithinBudget", 64'(done), 64'(1));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int stalls;

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        curOp  = OP_ADDI;
        curImm = 0;
        modelEnable = 1'b1;
        nextCycle();
        compareEnable = 1'b1;

        @(negedge clock);
        checkOutput("resetPcWrite", 64'(pc_write), 64'(0));
        checkOutput("resetBubble",  64'(bubble),   64'(1));
        checkOutput("resetBusy",    64'(busy_mask), 64'(0));
        nextCycle();
        reset = 1'b0;

        // ADDI x1,x0,10 then ADD x3,x1,x2
        $display("[TB] directed: dependent ADD after ADDI");
        runInstr(OP_ADDI, 1, 0, 0, 10, stalls);
        checkOutput("t1AddiStalls", 64'(stalls), 64'(0));
        runInstr(OP_ADD, 3, 1, 2, 0, stalls);
        checkOutput("t1AddStalls", 64'(stalls), 64'(3));
        checkOutput("t1StallCount", 64'(stall_count), 64'(3));

        // Short program with register-file results
        $display("[TB] directed: five-instruction program");
        doReset();
        runInstr(OP_ADDI, 1, 0, 0, 10, stalls);
        runInstr(OP_ADDI, 2, 0, 0, 3, stalls);
        runInstr(OP_ADD,  3, 1, 2, 0, stalls);
        runInstr(OP_SUB,  4, 1, 2, 0, stalls);
        runInstr(OP_ADDI, 5, 1, 0, -5, stalls);
        repeat (4) nextCycle();
        checkOutput("t2x1", 64'(regs[1]), 64'(10));
        checkOutput("t2x2", 64'(regs[2]), 64'(3));
        checkOutput("t2x3", 64'(regs[3]), 64'(13));
        checkOutput("t2x4", 64'(regs[4]), 64'(7));
        checkOutput("t2x5", 64'(regs[5]), 64'(5));

        // Writes to x0 never create pending state
        $display("[TB] directed: x0 destination and sources");
        doReset();
        runInstr(OP_ADDI, 0, 0, 0, 1, stalls);
        checkOutput("t3AddiBusy", 64'(busy_mask), 64'(0));
        runInstr(OP_ADD, 2, 0, 0, 0, stalls);
        checkOutput("t3AddStalls", 64'(stalls), 64'(0));
        checkOutput("t3AddBusy", 64'(busy_mask), 64'(32'h4));

        // Flush while a hazard is pending
        $display("[TB] directed: flush over stall");
        doReset();
        runInstr(OP_ADDI, 1, 0, 0, 10, stalls);
        curOp = OP_ADD;
        applyStimulus(1, 1, 2, 1, 1, 3, 1, 1);
        @(negedge clock);
        checkOutput("t4RawHazard", 64'(raw_hazard), 64'(1));
        checkOutput("t4PcWrite",   64'(pc_write),   64'(1));
        checkOutput("t4IfId",      64'(if_id_write), 64'(1));
        checkOutput("t4Bubble",    64'(bubble),     64'(1));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4StallCount", 64'(stall_count), 64'(0));
        checkOutput("t4IssueCount", 64'(issue_count), 64'(1));
        checkOutput("t4Busy",       64'(busy_mask),   64'(32'h2));

        // Two writers to x1 back to back, then a reader
        $display("[TB] directed: back-to-back writers");
        doReset();
        runInstr(OP_ADDI, 1, 0, 0, 10, stalls);
        runInstr(OP_ADDI, 1, 0, 0, 20, stalls);
        checkOutput("t5SecondStalls", 64'(stalls), 64'(0));
        runInstr(OP_ADD, 3, 1, 1, 0, stalls);
        checkOutput("t5AddStalls", 64'(stalls), 64'(3));
        checkOutput("t5BusyX1", 64'(busy_mask[1]), 64'(0));
        repeat (4) nextCycle();
        checkOutput("t5x3", 64'(regs[3]), 64'(40));

        // Scoreboard pinned so the stall outlives the write-back window, then reset mid-stall
        $display("[TB] directed: over-long stall and reset");
        doReset();
        compareEnable = 1'b0;
        modelEnable   = 1'b0;
        force dut.r_slotValid = {WB{1'b1}};
        force dut.r_slotRd    = {WB{5'd7}};
        curOp = OP_ADD;
        applyStimulus(1, 7, 7, 1, 1, 8, 1, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checkOutput("t6RawHazard", 64'(raw_hazard), 64'(1));
            checkOutput("t6PcWrite",   64'(pc_write),   64'(0));
            nextCycle();
            if (c == 2) checkOutput("t6ErrAfter3", 64'(hazard_error), 64'(0));
            if (c == 3) checkOutput("t6ErrAfter4", 64'(hazard_error), 64'(1));
        end
        checkOutput("t6StallCount", 64'(stall_count), 64'(5));
        release dut.r_slotValid;
        release dut.r_slotRd;
        modelEnable = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t6RstPcWrite", 64'(pc_write),    64'(0));
        checkOutput("t6RstIfId",    64'(if_id_write), 64'(0));
        checkOutput("t6RstBubble",  64'(bubble),      64'(1));
        checkOutput("t6RstHazard",  64'(raw_hazard),  64'(0));
        nextCycle();
        checkOutput("t6RstBusy",     64'(busy_mask),    64'(0));
        checkOutput("t6RstStallCnt", 64'(stall_count),  64'(0));
        checkOutput("t6RstIssueCnt", 64'(issue_count),  64'(0));
        checkOutput("t6RstErr",      64'(hazard_error), 64'(0));
        reset = 1'b0;
        compareEnable = 1'b1;
        @(negedge clock);
        checkOutput("t6FreeIssue", 64'(pc_write), 64'(1));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic over a small register window to provoke hazards and counter saturation
        $display("[TB] random phase");
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 9) < 8,
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) == 0);
            nextCycle();
        end
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
